// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: op classes, major opcodes and the canonical NOP.
// Used by both the instruction encoder and the decoder.
package riscv_pkg;

    typedef enum logic [3:0] {
        OP_R      = 4'd0,
        OP_OPIMM  = 4'd1,
        OP_LOAD   = 4'd2,
        OP_STORE  = 4'd3,
        OP_BRANCH = 4'd4,
        OP_JAL    = 4'd5,
        OP_JALR   = 4'd6,
        OP_LUI    = 4'd7,
        OP_AUIPC  = 4'd8,
        OP_SYSTEM = 4'd9
    } op_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; storage is not reset,
// the occupancy count alone defines which entries are meaningful.
module enc_fifo2 #(
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a request into its format, substitutes a
// flagged NOP for anything unencodable, and queues words in a 2-entry FIFO.
module instr_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic        in_sub,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_illegal,
    output logic [15:0] instr_count
);

    localparam int DATA_W = 33;

    // True when imm[31:lsb] is a pure sign extension.
    function automatic logic sext_ok(input logic [31:0] v, input int lsb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << lsb;
        return ((v & m) == 32'd0) || ((v & m) == m);
    endfunction

    op_class_t         op;
    logic [31:0]       imm;
    logic [31:0]       word_p0;
    logic              illegal_p0;
    logic [31:0]       enc_word_p0;
    logic              vld_p0;
    logic              pop;
    logic              run_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    assign op  = op_class_t'(in_op);
    assign imm = in_imm;

    always_comb begin
        word_p0    = NOP_INSTR;
        illegal_p0 = 1'b0;
        case (op)
            OP_R: begin
                word_p0 = {(in_sub ? 7'h20 : 7'h00), in_rs2, in_rs1, in_funct3, in_rd, OPC_R};
            end
            OP_OPIMM: begin
                illegal_p0 = !sext_ok(imm, 11);
                word_p0    = {imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
            end
            OP_LOAD: begin
                illegal_p0 = !sext_ok(imm, 11);
                word_p0    = {imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
            end
            OP_JALR: begin
                illegal_p0 = !sext_ok(imm, 11);
                word_p0    = {imm[11:0], in_rs1, 3'd0, in_rd, OPC_JALR};
            end
            OP_SYSTEM: begin
                // Only ECALL (0) and EBREAK (1) are expressible.
                illegal_p0 = (imm[31:1] != 31'd0);
                word_p0    = {imm[11:0], 5'd0, 3'd0, 5'd0, OPC_SYSTEM};
            end
            OP_STORE: begin
                illegal_p0 = !sext_ok(imm, 11);
                word_p0    = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], OPC_STORE};
            end
            OP_BRANCH: begin
                illegal_p0 = !sext_ok(imm, 12) || imm[0];
                word_p0    = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct3,
                              imm[4:1], imm[11], OPC_BRANCH};
            end
            OP_JAL: begin
                illegal_p0 = !sext_ok(imm, 20) || imm[0];
                word_p0    = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, OPC_JAL};
            end
            OP_LUI: begin
                illegal_p0 = (imm[11:0] != 12'd0);
                word_p0    = {imm[31:12], in_rd, OPC_LUI};
            end
            OP_AUIPC: begin
                illegal_p0 = (imm[11:0] != 12'd0);
                word_p0    = {imm[31:12], in_rd, OPC_AUIPC};
            end
            default: illegal_p0 = 1'b1;
        endcase
        if (in_sub && ((op != OP_R) || (in_funct3 != 3'd0))) illegal_p0 = 1'b1;
    end

    assign enc_word_p0 = illegal_p0 ? NOP_INSTR : word_p0;
    assign vld_p0      = in_valid && in_ready;

    // ---- p0 -> FIFO boundary ----
    enc_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (vld_p0),
        .wr_data ({illegal_p0, enc_word_p0}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Holds in_ready low during reset and releases it one edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    assign in_ready    = run_q && !fifo_full;
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign out_instr   = fifo_empty ? 32'd0 : head[31:0];
    assign out_illegal = !fifo_empty && head[32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   instr_count <= 16'd0;
        else if (pop) instr_count <= instr_count + 16'd1;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic, scored
// against a queue model whose words are built from the RV32I field rules.
module tb_instr_encoder;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_op = 4'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic        in_sub = 1'b0;
    logic [31:0] in_imm = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic [15:0] instr_count;

    int          ncmp = 0;
    int          nerr = 0;
    logic [32:0] q[$];
    logic [15:0] cnt_m = 16'd0;
    bit          run_m = 1'b0;

    instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_sub      (in_sub),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_illegal (out_illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Reference: {illegal, word} from the ISA field definitions and value ranges.
    function automatic logic [32:0] ref_enc(input logic [3:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic sub,
                                            input logic [31:0] imm);
        int          si;
        bit          ill;
        logic [31:0] w, r1, r2, d, f;
        si = $signed(imm);
        ill = 1'b0;
        r1 = 32'(rs1) << 15;
        r2 = 32'(rs2) << 20;
        d  = 32'(rd) << 7;
        f  = 32'(f3) << 12;
        w  = 32'd0;
        case (op)
            4'd0: w = ((sub ? 32'h20 : 32'h0) << 25) | r2 | r1 | f | d | 32'h33;
            4'd1, 4'd2, 4'd6: begin
                ill = (si < -2048) || (si > 2047);
                w = ((imm & 32'hFFF) << 20) | r1 | d;
                if (op == 4'd1) w = w | f | 32'h13;
                if (op == 4'd2) w = w | f | 32'h03;
                if (op == 4'd6) w = w | 32'h67;
            end
            4'd9: begin
                ill = (imm > 32'd1);
                w = ((imm & 32'hFFF) << 20) | 32'h73;
            end
            4'd3: begin
                ill = (si < -2048) || (si > 2047);
                w = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | f | ((imm & 32'h1F) << 7) | 32'h23;
            end
            4'd4: begin
                ill = (si < -4096) || (si > 4095) || (imm % 2 != 0);
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 | f
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            end
            4'd5: begin
                ill = (si < -(1 << 20)) || (si > (1 << 20) - 1) || (imm % 2 != 0);
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
            end
            4'd7, 4'd8: begin
                ill = ((imm & 32'hFFF) != 32'd0);
                w = (imm & 32'hFFFF_F000) | d | ((op == 4'd7) ? 32'h37 : 32'h17);
            end
            default: ill = 1'b1;
        endcase
        if (sub && ((op != 4'd0) || (f3 != 3'd0))) ill = 1'b1;
        if (ill) w = 32'h13;
        return {ill, w};
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        ncmp++;
        nerr++;
        $error("FAIL %s: bound expired", tag);
    endtask

    // One clock: inputs already driven after a falling edge; returns at the next falling edge.
    task automatic cycle(output bit acc);
        bit pop;
        bit exp_rdy;
        #1;
        exp_rdy = run_m && (q.size() < 2);
        chk("in_ready", 33'(in_ready), 33'(exp_rdy));
        chk("out_valid", 33'(out_valid), 33'(q.size() != 0));
        acc = in_valid && exp_rdy;
        pop = (q.size() != 0) && out_ready;
        if (pop) chk("head", {out_illegal, out_instr}, q[0]);
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            cnt_m = cnt_m + 16'd1;
        end
        if (acc) q.push_back(ref_enc(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_sub, in_imm));
        if (rst_n) run_m = 1'b1;
        #1 chk("instr_count", 33'(instr_count), 33'(cnt_m));
        @(negedge clk);
    endtask

    task automatic set_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic sub,
                           input logic [31:0] imm);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_sub = sub; in_imm = imm;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic sub,
                        input logic [31:0] imm);
        bit acc;
        int n;
        set_req(op, rd, rs1, rs2, f3, sub, imm);
        in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            cycle(acc);
            n++;
        end
        if (!acc) timeout_fail("send");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        out_ready = 1'b1;
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            cycle(acc);
            n++;
        end
        if (q.size() != 0) timeout_fail("drain");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 33'(out_valid), 33'd0);
        chk("rst_in_ready", 33'(in_ready), 33'd0);
        chk("rst_out_word", {out_illegal, out_instr}, 33'd0);
        chk("rst_count", 33'(instr_count), 33'd0);
        q.delete();
        cnt_m = 16'd0;
        run_m = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hold_valid", 33'(out_valid), 33'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int n;
        logic [31:0] r;

        @(negedge clk);
        do_reset();
        out_ready = 1'b0;
        cycle(acc);
        chk("ready_after_rst", 33'(in_ready), 33'd1);

        // Directed encodings, each checked one cycle after accept.
        send(OP_OPIMM, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'd5);
        chk("opimm", {out_illegal, out_instr}, {1'b0, 32'h0051_0093});
        drain();
        send(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
        chk("r_sub", {out_illegal, out_instr}, {1'b0, 32'h4020_81B3});
        drain();
        send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8);
        chk("branch", {out_illegal, out_instr}, {1'b0, 32'h0020_8463});
        drain();
        send(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
        chk("lui", {out_illegal, out_instr}, {1'b0, 32'h1234_52B7});
        drain();
        send(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
        chk("jal_odd", {out_illegal, out_instr}, {1'b1, 32'h0000_0013});
        drain();

        // Backpressure: three back-to-back requests with the consumer stalled.
        @(negedge clk);
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_req(OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
        cycle(acc);
        cycle(acc);
        set_req(OP_STORE, 5'd0, 5'd4, 5'd6, 3'd2, 1'b0, 32'hFFFF_FFF8);
        cycle(acc);
        set_req(OP_AUIPC, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000);
        cycle(acc);
        chk("full_stall", 33'(in_ready), 33'd0);
        out_ready = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            cycle(acc);
            n++;
        end
        if (!acc) timeout_fail("third_accept");
        drain();
        chk("count_three", 33'(instr_count), 33'd3);

        // Random traffic across all classes, including undefined codes.
        repeat (1500) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: r = 32'($signed($urandom_range(0, 32)) - 16);
                1: r = 32'($signed($urandom_range(0, 8191)) - 4096);
                2: r = $urandom() & 32'hFFFF_F000;
                default: r = $urandom();
            endcase
            set_req(4'($urandom_range(0, 11)), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                    3'($urandom_range(0, 1) * $urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0), r);
            cycle(acc);
        end
        drain();

        // Counter wrap at 16'hFFFF.
        @(negedge clk);
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_req(OP_OPIMM, 5'd2, 5'd3, 5'd0, 3'd0, 1'b0, 32'd7);
        n = 0;
        while (cnt_m != 16'hFFFF && n < 70000) begin
            cycle(acc);
            n++;
        end
        if (cnt_m != 16'hFFFF) timeout_fail("preload");
        in_valid = 1'b0;
        chk("count_max", 33'(instr_count), 33'h0FFFF);
        n = 0;
        while (cnt_m != 16'd0 && n < 10) begin
            cycle(acc);
            n++;
        end
        if (cnt_m != 16'd0) timeout_fail("wrap");
        chk("count_wrap", 33'(instr_count), 33'd0);
        drain();

        // Reset mid-operation with two words queued.
        out_ready = 1'b0;
        send(OP_LOAD, 5'd8, 5'd9, 5'd0, 3'd2, 1'b0, 32'd16);
        send(OP_JALR, 5'd1, 5'd5, 5'd0, 3'd7, 1'b0, 32'hFFFF_FFFC);
        chk("queued_two", 33'(in_ready), 33'd0);
        do_reset();
        out_ready = 1'b1;
        repeat (3) cycle(acc);
        chk("post_rst_count", 33'(instr_count), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have one clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when high with in_valid.
- in_op  in  4  op class (op_class_t).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_sub  in  1  selects funct7 = 7'h20.
- in_imm  in  32  signed immediate; U-type takes the full value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer ready.
- out_instr  out  32  RV32I instruction word.
- out_illegal  out  1  request was unencodable; NOP substituted.
- instr_count  out  16  words delivered.

Function
REQ-003 Request transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-004 Accepted requests SHALL be encoded combinationally and pushed into a 2-entry FIFO.
REQ-005 out_instr and out_illegal SHALL come from the FIFO head; latency from accept edge to out_valid high SHALL be 1 cycle.
REQ-006 in_ready SHALL equal "FIFO not full" (count < 2), independent of in_valid.
REQ-007 Push and pop in the same cycle SHALL leave the count unchanged; when full, a pop SHALL NOT enable a same-cycle push.
REQ-008 FIFO read/write pointers SHALL be 1 bit each and wrap 1->0.
REQ-009 Opcodes per class:
- R 0110011
- OPIMM 0010011
- LOAD 0000011
- STORE 0100011
- BRANCH 1100011
- JAL 1101111
- JALR 1100111
- LUI 0110111
- AUIPC 0010111
- SYSTEM 1110011
REQ-010 R format SHALL be {funct7, rs2, rs1, funct3, rd, opcode}, with funct7 = in_sub ? 7'h20 : 7'h00.
REQ-011 I format (OPIMM, LOAD, JALR, SYSTEM) SHALL be {imm[11:0], rs1, funct3, rd, opcode}; JALR SHALL force funct3 = 0; SYSTEM SHALL force rs1, rd and funct3 to 0.
REQ-012 S format SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-013 B format SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-014 U format SHALL be {imm[31:12], rd, opcode}.
REQ-015 J format SHALL be {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-016 A request SHALL be illegal when any of the following holds:
- I or S class and imm[31:11] not all equal.
- BRANCH and imm[31:12] not all equal, or imm[0] = 1.
- JAL and imm[31:20] not all equal, or imm[0] = 1.
- U class and imm[11:0] != 0.
- SYSTEM and imm is not 0 or 1.
- in_sub = 1 with class != R, or with funct3 != 0.
- in_op is an undefined code.
REQ-017 An illegal request SHALL be consumed normally, with out_instr = 32'h00000013 and out_illegal = 1.
REQ-018 instr_count SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 0.

Reset
REQ-019 While rst_n is low the FIFO SHALL be empty, out_valid = 0, in_ready = 0, out_instr = 0, out_illegal = 0 and instr_count = 0.
REQ-020 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-021 Reset asserted mid-operation SHALL discard all queued words without emitting them.

Structure
REQ-022 op_class_t, the opcode constants and the NOP constant SHALL live in the shared package `riscv_pkg`, also used by the decoder.
REQ-023 The encoder SHALL contain one sub-module, `enc_fifo2`, a parameterised 2-entry FIFO with 33-bit data {illegal, instr}; format packing SHALL remain in instr_encoder.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- OPIMM rd=1, rs1=2, f3=0, imm=5 -> 0x00510093, illegal=0, one cycle after accept.
- R sub rd=3, rs1=1, rs2=2 -> 0x402081B3; BRANCH rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463.
- LUI rd=5, imm=0x12345000 -> 0x123452B7; JAL imm=3 -> 0x00000013 with illegal=1.
- out_ready=0 with 3 back-to-back requests -> in_ready low after 2 accepts; after out_ready=1, the 3 words emerge in order; instr_count = 3.
- instr_count preloaded by 65535 transfers, one more transfer -> 0; rst_n pulsed low with 2 queued -> out_valid=0, nothing emitted, count=0.
